// File: rtl/idct_acc_pkg.sv
// Shared types and defaults for the IDCT accumulate/round block.
package idct_acc_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, WAIT} state_e;

  localparam int DEF_IN_WIDTH  = 32;
  localparam int DEF_ACC_TERMS = 8;
  localparam int DEF_SHIFT     = 8;
  localparam int DEF_OUT_WIDTH = 16;

  // Enough headroom to sum `terms` full-scale products without overflow.
  function automatic int acc_width(input int in_w, input int terms);
    return in_w + $clog2(terms);
  endfunction

endpackage

// File: rtl/idct_acc_round_sat.sv
// Round-half-up, arithmetic shift and output reduction of one accumulated row.
// Saturation is enabled by defining IDCT_ACC_SAT_EN; otherwise the result wraps.
module idct_acc_round_sat
  import idct_acc_pkg::*;
#(
  parameter int ACC_W     = acc_width(DEF_IN_WIDTH, DEF_ACC_TERMS),
  parameter int SHIFT     = DEF_SHIFT,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic signed [ACC_W-1:0]     sum,
  output logic signed [OUT_WIDTH-1:0] y,
  output logic                        sat
);

  // One extra bit so adding the rounding constant cannot overflow.
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
  localparam logic signed [RW-1:0] MAXV = (RW'(1) <<< (OUT_WIDTH - 1)) - RW'(1);
  localparam logic signed [RW-1:0] MINV = -(RW'(1) <<< (OUT_WIDTH - 1));

  logic signed [RW-1:0] sum_x, rnd, sh;

  assign sum_x = {sum[ACC_W-1], sum};
  assign rnd   = sum_x + HALF;
  assign sh    = rnd >>> SHIFT;

`ifdef IDCT_ACC_SAT_EN
  always_comb begin
    y   = sh[OUT_WIDTH-1:0];
    sat = 1'b0;
    if (sh > MAXV) begin
      y   = MAXV[OUT_WIDTH-1:0];
      sat = 1'b1;
    end else if (sh < MINV) begin
      y   = MINV[OUT_WIDTH-1:0];
      sat = 1'b1;
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^{sh[RW-1:OUT_WIDTH], MAXV, MINV};
  assign y   = sh[OUT_WIDTH-1:0];
  assign sat = 1'b0;
`endif

endmodule

// File: rtl/idct_acc_round.sv
// Accumulates ACC_TERMS signed products per row, then rounds/shifts into y_out.
// Optional clamping with sticky sat_flag when IDCT_ACC_SAT_EN is defined.
module idct_acc_round
  import idct_acc_pkg::*;
#(
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int ACC_TERMS = DEF_ACC_TERMS,
  parameter int SHIFT     = DEF_SHIFT,
  parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        clr,
  input  logic signed [IN_WIDTH-1:0]  p_in,
  input  logic                        p_valid,
  output logic                        p_ready,
  output logic signed [OUT_WIDTH-1:0] y_out,
  output logic                        y_valid,
  input  logic                        y_ready,
  output logic                        sat_flag
);

  localparam int ACC_W = acc_width(IN_WIDTH, ACC_TERMS);
  localparam int CNT_W = $clog2(ACC_TERMS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_TERMS - 1);

  state_e                      state;
  logic signed [ACC_W-1:0]     acc, sum;
  logic [CNT_W-1:0]            cnt, cnt_inc;
  logic signed [OUT_WIDTH-1:0] y_next;
  logic                        sat_next, accept, hold, last;

  assign p_ready = (state != WAIT);
  assign accept  = p_valid && p_ready;
  // Current result will still be pending after this edge.
  assign hold    = y_valid && !y_ready;
  assign last    = (cnt == LAST);
  assign cnt_inc = cnt + CNT_W'(1);
  assign sum     = acc + {{(ACC_W-IN_WIDTH){p_in[IN_WIDTH-1]}}, p_in};

  idct_acc_round_sat #(
    .ACC_W    (ACC_W),
    .SHIFT    (SHIFT),
    .OUT_WIDTH(OUT_WIDTH)
  ) u_rs (
    .sum(sum),
    .y  (y_next),
    .sat(sat_next)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= IDLE;
      acc      <= '0;
      cnt      <= '0;
      y_out    <= '0;
      y_valid  <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      if (y_ready) y_valid <= 1'b0;
      if (clr) begin
        state    <= IDLE;
        acc      <= '0;
        cnt      <= '0;
        sat_flag <= 1'b0;
      end else begin
        case (state)
          IDLE, ACCUM: begin
            if (accept && last) begin
              // Final term: publish result and start the next row on this edge.
              state   <= IDLE;
              acc     <= '0;
              cnt     <= '0;
              y_out   <= y_next;
              y_valid <= 1'b1;
              if (sat_next) sat_flag <= 1'b1;
            end else if (accept) begin
              acc   <= sum;
              cnt   <= cnt_inc;
              // Stall before the final term if the previous result is still pending.
              state <= (cnt_inc == LAST && hold) ? WAIT : ACCUM;
            end else if (state == ACCUM && last && hold) begin
              state <= WAIT;
            end
          end
          WAIT:    if (!hold) state <= ACCUM;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_idct_acc_round.sv
// Directed self-checking bench for idct_acc_round at default parameters.
module tb_idct_acc_round;

  logic               clk, rstN, clr, p_valid, p_ready, y_valid, y_ready, sat_flag;
  logic signed [31:0] p_in;
  logic signed [15:0] y_out;
  int checks   = 0;
  int failures = 0;

  idct_acc_round dut (
    .clk(clk), .rstN(rstN), .clr(clr), .p_in(p_in), .p_valid(p_valid),
    .p_ready(p_ready), .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready),
    .sat_flag(sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one product and hold it until accepted (bounded).
  task automatic feed(input logic signed [31:0] v);
    int n;
    n = 0;
    p_valid = 1'b1;
    p_in    = v;
    while (!p_ready && n < 40) begin
      tick();
      n++;
    end
    if (!p_ready) begin
      checks++; failures++;
      $display("FAIL feed_timeout p_ready=%0b required=1", p_ready);
    end
    tick();
  endtask

  task automatic feed_n(input logic signed [31:0] v, input int n);
    for (int i = 0; i < n; i++) feed(v);
    p_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b1;
    #1 rstN = 1'b0;
    #1;
    checks++; if (y_out !== 16'sd0) begin failures++; $display("FAIL rst_y_out got=%0d exp=0", y_out); end
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL rst_y_valid got=%0b exp=0", y_valid); end
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL rst_sat got=%0b exp=0", sat_flag); end
    tick(); tick();
    rstN = 1'b1;
    tick();
    checks++; if (p_ready !== 1'b1) begin failures++; $display("FAIL rst_p_ready got=%0b exp=1", p_ready); end
  endtask

  task automatic test_basic();
    y_ready = 1'b1;
    feed_n(256, 7);
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%0b exp=0", y_valid); end
    feed_n(256, 1);
    checks++; if (y_valid !== 1'b1 || y_out !== 16'sd8) begin
      failures++; $display("FAIL basic_result valid=%0b y=%0d exp valid=1 y=8", y_valid, y_out); end
    tick();
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL basic_consumed got=%0b exp=0", y_valid); end
  endtask

  task automatic test_round();
    feed_n(48, 8);
    checks++; if (y_out !== 16'sd2) begin failures++; $display("FAIL round_pos got=%0d exp=2", y_out); end
    feed_n(-48, 8);
    checks++; if (y_out !== -16'sd1) begin failures++; $display("FAIL round_neg got=%0d exp=-1", y_out); end
  endtask

  task automatic test_sat();
    logic signed [15:0] exp_p, exp_n;
    logic               exp_s;
`ifdef IDCT_ACC_SAT_EN
    exp_p = 16'sd32767; exp_n = -16'sd32768; exp_s = 1'b1;
`else
    exp_p = 16'sd0;     exp_n = 16'sd0;      exp_s = 1'b0;
`endif
    feed_n(32'sh4000_0000, 8);
    checks++; if (y_out !== exp_p) begin failures++; $display("FAIL sat_pos_y got=%0d exp=%0d", y_out, exp_p); end
    checks++; if (sat_flag !== exp_s) begin failures++; $display("FAIL sat_pos_flag got=%0b exp=%0b", sat_flag, exp_s); end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (sat_flag !== 1'b0) begin failures++; $display("FAIL sat_clr_flag got=%0b exp=0", sat_flag); end
    checks++; if (y_out !== exp_p) begin failures++; $display("FAIL sat_clr_keeps_y got=%0d exp=%0d", y_out, exp_p); end
    feed_n(32'shC000_0000, 8);
    checks++; if (y_out !== exp_n || sat_flag !== exp_s) begin
      failures++; $display("FAIL sat_neg y=%0d sat=%0b exp y=%0d sat=%0b", y_out, sat_flag, exp_n, exp_s); end
    tick();
  endtask

  task automatic test_backpressure();
    y_ready = 1'b0;
    feed_n(256, 8);
    feed_n(512, 7);
    checks++; if (p_ready !== 1'b0) begin failures++; $display("FAIL bp_stall got=%0b exp=0", p_ready); end
    p_valid = 1'b1; p_in = 512;
    tick(); tick(); tick();
    checks++; if (p_ready !== 1'b0) begin failures++; $display("FAIL bp_still_stalled got=%0b exp=0", p_ready); end
    checks++; if (y_valid !== 1'b1) begin failures++; $display("FAIL bp_row1_valid got=%0b exp=1", y_valid); end
    checks++; if (y_out !== 16'sd8) begin failures++; $display("FAIL bp_row1_held got=%0d exp=8", y_out); end
    y_ready = 1'b1;
    tick();
    checks++; if (p_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b exp=1", p_ready); end
    checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL bp_row1_taken got=%0b exp=0", y_valid); end
    tick();
    p_valid = 1'b0;
    checks++; if (y_valid !== 1'b1) begin failures++; $display("FAIL bp_row2_valid got=%0b exp=1", y_valid); end
    checks++; if (y_out !== 16'sd16) begin failures++; $display("FAIL bp_row2_y got=%0d exp=16", y_out); end
    tick();
  endtask

  task automatic test_clr();
    feed_n(1000, 4);
    clr = 1'b1; p_valid = 1'b1; p_in = 99999;
    tick();
    clr = 1'b0; p_valid = 1'b0;
    checks++; if (y_out !== 16'sd16) begin failures++; $display("FAIL clr_keeps_y got=%0d exp=16", y_out); end
    feed_n(256, 8);
    checks++; if (y_out !== 16'sd8) begin failures++; $display("FAIL clr_restart got=%0d exp=8", y_out); end
    tick();
  endtask

  task automatic test_rst_mid();
    feed_n(1000, 4);
    rstN = 1'b0;
    #3;
    checks++; if (y_out !== 16'sd0 || y_valid !== 1'b0) begin
      failures++; $display("FAIL rst_mid_async y=%0d valid=%0b exp y=0 valid=0", y_out, y_valid); end
    rstN = 1'b1;
    tick();
    feed_n(256, 8);
    checks++; if (y_out !== 16'sd8 || y_valid !== 1'b1) begin
      failures++; $display("FAIL rst_mid_restart y=%0d valid=%0b exp y=8 valid=1", y_out, y_valid); end
  endtask

  initial begin
    rstN = 1'b1; clr = 1'b0; p_valid = 1'b0; p_in = '0; y_ready = 1'b1;
    test_reset();
    test_basic();
    test_round();
    test_sat();
    test_backpressure();
    test_clr();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
